// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Bundle between the multi-cycle control FSM and the MIPS datapath.
//   master : control FSM side (consumes OpCode/mem_ready, drives controls)
//   slave  : datapath/memory side
//   Signals:
//     OpCode[5:0]      instruction[31:26] from the datapath
//     mem_ready        data memory completes the current access this cycle
//     RegDst/AluSrc/MemtoReg, ALUOp[1:0]   datapath mux selects
//     RegWrite/MemRead/MemWrite/Branch/Jump/Jal/PCWrite   single-state strobes
//     state_o[2:0]     FSM state (FETCH=0 .. TRAP=5)
//     trap, trap_cause[1:0], instr_count[CNT_W-1:0]   status
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 16);
   logic [5:0]       OpCode;
   logic             mem_ready;
   logic             RegDst;
   logic             AluSrc;
   logic             MemtoReg;
   logic [1:0]       ALUOp;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             Branch;
   logic             Jump;
   logic             Jal;
   logic             PCWrite;
   logic [2:0]       state_o;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  OpCode, mem_ready,
      output RegDst, AluSrc, MemtoReg, ALUOp,
             RegWrite, MemRead, MemWrite, Branch, Jump, Jal, PCWrite,
             state_o, trap, trap_cause, instr_count
   );

   modport slave (
      output OpCode, mem_ready,
      input  RegDst, AluSrc, MemtoReg, ALUOp,
             RegWrite, MemRead, MemWrite, Branch, Jump, Jal, PCWrite,
             state_o, trap, trap_cause, instr_count
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB,
//   with a mem_ready handshake + timeout, a sticky TRAP state for illegal
//   opcodes / memory timeouts, and a retired-instruction counter.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    mips_multicycle_ctrl_if.master (opcode/mem_ready in, controls out)
//   Strobes are decoded from the state register (plus live OpCode in DECODE
//   and mem_ready in MEM), so an asynchronous reset forces them low at once.
module mips_multicycle_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   mips_multicycle_ctrl_if.master        bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [7:0]       TMO_LIM = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q;

   logic reg_write, mem_read, mem_write, branch, jump, jal, pc_write;
   logic sel_vld;

   // Next state and strobes.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      tmo_d     = tmo_q;
      trap_d    = trap_q;
      cause_d   = cause_q;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      jal       = 1'b0;
      pc_write  = 1'b0;
      unique case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            op_d = bus.OpCode;
            case (bus.OpCode)
               OP_J: begin
                  jump     = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_JAL: begin
                  jump     = 1'b1;
                  jal      = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_d = S_EXEC;
               default: begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_BEQ: begin
                  branch   = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_LW, OP_SW: begin
                  tmo_d   = 8'd0;
                  state_d = S_MEM;
               end
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
            // mem_ready takes priority over a timeout landing on the same cycle
            if (bus.mem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_d == TMO_LIM) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b10;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
         tmo_q   <= 8'd0;
         trap_q  <= 1'b0;
         cause_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tmo_q   <= tmo_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
         if (pc_write) cnt_q <= cnt_q + CNT_ONE;
      end
   end

   // Mux selects only mean something once the opcode register holds the
   // current instruction; gating keeps them at 0 in reset, FETCH, DECODE
   // and TRAP (op_q resets to the R-type encoding).
   assign sel_vld = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

   assign bus.RegDst   = sel_vld && (op_q == OP_R);
   assign bus.AluSrc   = sel_vld && ((op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI));
   assign bus.MemtoReg = sel_vld && (op_q == OP_LW);
   assign bus.ALUOp    = !sel_vld           ? 2'b00 :
                         (op_q == OP_R)     ? 2'b10 :
                         (op_q == OP_BEQ)   ? 2'b01 : 2'b00;

   assign bus.RegWrite    = reg_write;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.Branch      = branch;
   assign bus.Jump        = jump;
   assign bus.Jal         = jal;
   assign bus.PCWrite     = pc_write;
   assign bus.state_o     = state_q;
   assign bus.trap        = trap_q;
   assign bus.trap_cause  = cause_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM directly upstream of the MIPS datapath.
- Consumes the datapath's OpCode output and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, Jal and ALUOp so that state-changing strobes are asserted for exactly one qualified cycle per instruction.
- Adds a data-memory ready handshake with timeout, a sticky trap on illegal opcodes or timeouts, and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MEM_TIMEOUT, 8, maximum MEM-state cycles waiting for mem_ready before trapping (valid range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- OpCode  in  6  Instruction[31:26] from the datapath.
- mem_ready  in  1  data memory completes the current access this cycle.
- RegDst, AluSrc, MemtoReg  out  1 each  datapath mux selects; level signals decoded from the latched opcode.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded; level signal from the latched opcode.
- RegWrite, MemRead, MemWrite, Branch, Jump, Jal  out  1 each  single-state strobes.
- PCWrite  out  1  PC update enable; one cycle per retired instruction.
- state_o  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH; latched opcode=0; all strobes and mux selects 0; ALUOp=00; trap=0; trap_cause=00; instr_count=0; timeout counter=0.
- Reset asserted mid-instruction aborts it immediately. No strobe may glitch high during reset.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
- Mux selects and ALUOp are combinational decodes of the opcode register, stable from EXEC to instruction end.
  - R: RegDst=1, ALUOp=10.
  - lw: AluSrc=1, MemtoReg=1, ALUOp=00.
  - sw: AluSrc=1, ALUOp=00.
  - addi: AluSrc=1, ALUOp=00.
  - beq: ALUOp=01.
  - Otherwise 0.
- FETCH: no strobes. Next state DECODE.
- DECODE: OpCode is latched into the opcode register on this state's clock edge. Next state depends on OpCode:
  - Illegal: TRAP, with trap_cause=01.
  - j: assert Jump=1, PCWrite=1 in DECODE; next state FETCH.
  - jal: assert Jump=1, Jal=1, PCWrite=1 in DECODE; next state FETCH.
  - Other legal opcodes: EXEC.
- EXEC:
  - beq: Branch=1, PCWrite=1; next FETCH. The PC mux uses Branch&Zero.
  - lw/sw: next MEM; timeout counter cleared.
  - R/addi: next WB.
- MEM:
  - lw holds MemRead=1; sw holds MemWrite=1, until the cycle mem_ready=1 (inclusive).
  - On mem_ready=1: lw goes to WB; sw asserts PCWrite=1 that cycle and goes to FETCH.
  - Each cycle with mem_ready=0 increments the timeout counter. When it reaches MEM_TIMEOUT, next state is TRAP with trap_cause=10 and strobes drop.
  - If mem_ready=1 arrives on the same cycle the count reaches MEM_TIMEOUT, mem_ready wins: the access completes.
- WB: RegWrite=1, PCWrite=1; next FETCH.
- TRAP: all strobes 0; trap=1; stays in TRAP until reset.
- Latency in cycles with zero memory wait: j/jal 2, beq 3, R/addi 4, sw 4, lw 5. Each mem_ready=0 cycle adds 1.
- instr_count increments by 1 on every clock edge with PCWrite=1, wrapping from 2^CNT_W-1 to 0.
- Invariants:
  - At most one of RegWrite/MemRead/MemWrite is asserted in any cycle.
  - PCWrite is high exactly once per retired instruction.

Test Plan:
- R-type 000000 after reset -> states 0,1,2,4. RegWrite=1 and PCWrite=1 only in the 4th cycle; RegDst=1, ALUOp=10; instr_count=1.
- lw 100011 with mem_ready low 2 cycles then high -> MemRead high 3 cycles, then WB with RegWrite=1, MemtoReg=1. Total 7 cycles; instr_count=1.
- sw 101011 with mem_ready never high, MEM_TIMEOUT=8 -> TRAP after 8 MEM cycles; trap=1, trap_cause=10; MemWrite low from the TRAP cycle onward; no PCWrite.
- Sequence j, jal, beq -> Jump=1 in cycle 2 (DECODE) for j and jal; Jal=1 for jal only; Branch=1 in cycle 3 for beq; instr_count=3 after 7 cycles.
- Illegal opcode 111111 -> trap_cause=01, state stuck at 5 for 20 cycles. Then reset pulse -> state=0, trap=0, instr_count=0.
- CNT_W=4, 17 back-to-back j instructions -> instr_count wraps from 15 to 0 and reads 1. Reset asserted mid-MEM of lw -> MemRead drops to 0 asynchronously.
